// File: rtl/pwm_dac_pkg.sv
// Shared types and helpers for the multi-channel PWM DAC.
package pwm_dac_pkg;

  typedef enum logic {
    ModeEdge   = 1'b0,
    ModeCenter = 1'b1
  } pwm_mode_e;

  function automatic pwm_mode_e mode_of(int unsigned center_aligned);
    return (center_aligned != 0) ? ModeCenter : ModeEdge;
  endfunction

  // Largest counter value for a given counter width.
  function automatic int unsigned cnt_max(int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // Duty is the cnt_w MSBs of a sample_w-bit sample; caller truncates the result.
  function automatic logic [63:0] extract_duty(logic [63:0] sample, int unsigned sample_w,
                                               int unsigned cnt_w);
    return sample >> (sample_w - cnt_w);
  endfunction

endpackage

// File: rtl/pwm_dac_counter.sv
// Shared PWM period counter: sawtooth (edge) or triangle (centre) with boundary pulse.
module pwm_dac_counter
  import pwm_dac_pkg::*;
#(
  parameter int unsigned CntW = 5,
  parameter pwm_mode_e   Mode = ModeEdge
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  output logic [CntW-1:0] count,
  output logic            boundary
);

  localparam logic [CntW-1:0] Max = CntW'(cnt_max(CntW));

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  logic [CntW-1:0] count_q, count_d;
  dir_e            dir_q, dir_d;

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (!enable) begin
      count_d = '0;
      dir_d   = DirUp;
    end else if (Mode == ModeEdge) begin
      count_d = count_q + 1'b1;
    end else if (dir_q == DirUp) begin
      // Each endpoint is held for one cycle when the direction turns.
      if (count_q == Max) dir_d = DirDown;
      else                count_d = count_q + 1'b1;
    end else begin
      if (count_q == '0) dir_d = DirUp;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= DirUp;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // A period begins on the first up-phase cycle at zero, including the enable rise.
  assign boundary = enable && (count_q == '0) && (dir_q == DirUp);
  assign count    = count_q;

endmodule

// File: rtl/pwm_dac.sv
// Multi-channel double-buffered PWM DAC; define PWM_DAC_DITHER_EN for
// first-order noise-shaped duty rounding.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = 24,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned CENTER_ALIGNED = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_i,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         period_start,
  output logic                         underrun,
  output logic [CNT_W-1:0]             count
);

  localparam pwm_mode_e Mode = mode_of(CENTER_ALIGNED);

  logic boundary;

  pwm_dac_counter #(
    .CntW (CNT_W),
    .Mode (Mode)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .count    (count),
    .boundary (boundary)
  );

  logic [CHANNELS*SAMPLE_W-1:0] pend_q, pend_d;
  logic                         pend_full_q, pend_full_d;
  logic                         accept, load;

  assign sample_ready = ~pend_full_q;
  assign accept       = sample_valid & sample_ready;
  assign load         = boundary & pend_full_q;
  assign period_start = boundary;
  assign underrun     = boundary & ~pend_full_q;

  // Load and accept are exclusive: accept needs pending empty, load needs it full.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load) pend_full_d = 1'b0;
    if (accept) begin
      pend_d      = sample_i;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  logic [CHANNELS-1:0] pwm_d, pwm_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SAMPLE_W-1:0] smp;
    logic [CNT_W-1:0]    trunc;
    logic [CNT_W-1:0]    duty_q, duty_d;

    assign smp   = pend_q[c*SAMPLE_W +: SAMPLE_W];
    assign trunc = CNT_W'(extract_duty(64'(smp), SAMPLE_W, CNT_W));

`ifdef PWM_DAC_DITHER_EN
    localparam int unsigned ResW = SAMPLE_W - CNT_W;
    localparam logic [CNT_W-1:0] Max = CNT_W'(cnt_max(CNT_W));

    logic [ResW-1:0] acc_q, acc_d;
    logic [ResW:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, smp[ResW-1:0]};

    // A carry at full scale is dropped but the accumulator still keeps its sum.
    always_comb begin
      acc_d  = acc_q;
      duty_d = duty_q;
      if (load) begin
        acc_d  = sum[ResW-1:0];
        duty_d = (sum[ResW] && (trunc != Max)) ? trunc + 1'b1 : trunc;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
    end
`else
    assign duty_d = load ? trunc : duty_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) duty_q <= '0;
      else        duty_q <= duty_d;
    end

    // Compare against the next duty so a fresh load governs count 0 of its period.
    assign pwm_d[c] = enable & (duty_d > count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end

  assign pwm_out = pwm_q;

endmodule
